audio_decimator: RTL and testbench

//  Upstream feeder of the SGTL5000 DSP-mode serial port. Takes stereo SID samples at the
//  SID sample rate, boxcar-averages 2**DECIM_LOG2 samples per channel, scales, saturates,
//  and holds a packed 64-bit frame {left_slot, right_slot} that the serial port loads on

---
 rtl/audio_pkg.sv | 21 ++
 rtl/audio_decimator_if.sv | 27 ++
 rtl/audio_sat_scale.sv | 44 ++++
 rtl/audio_decimator.sv | 142 ++++++++++++++
 tb/tb_audio_decimator.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio decimator: slot/frame layout and the
// dither LFSR seed and step function.
package audio_pkg;

    localparam int          SLOT_BITS  = 32;
    localparam int          FRAME_BITS = 64;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    typedef logic signed [SLOT_BITS-1:0] slot_t;

    typedef struct packed {
        slot_t left;
        slot_t right;
    } frame_t;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    function automatic logic [15:0] lfsrNext(input logic [15:0] s);
        lfsrNext = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

endpackage

// File: rtl/audio_decimator_if.sv
// Sample-in / frame-out bus of the audio decimator. The master drives samples and
// control strobes; the slave (the decimator) returns the held frame and status.
interface audio_decimator_if #(
    parameter int IN_BITS = 22
);
    import audio_pkg::*;

    logic                      in_valid;
    logic signed [IN_BITS-1:0] in_left;
    logic signed [IN_BITS-1:0] in_right;
    logic                      mute;
    logic                      clip_clr;
    frame_t                    audio_o;
    logic                      out_valid;
    logic                      clip;

    modport master (
        output in_valid, in_left, in_right, mute, clip_clr,
        input  audio_o, out_valid, clip
    );

    modport slave (
        input  in_valid, in_left, in_right, mute, clip_clr,
        output audio_o, out_valid, clip
    );

endinterface

// File: rtl/audio_sat_scale.sv
// Combinational per-channel post-processing: gain shift, optional dither add,
// averaging shift (floor), saturation to OUT_BITS and left-justification in a slot.
module audio_sat_scale
    import audio_pkg::*;
#(
    parameter int ACC_BITS   = 27,
    parameter int DECIM_LOG2 = 5,
    parameter int GAIN_SHIFT = 0,
    parameter int OUT_BITS   = 24
) (
    input  logic signed [ACC_BITS-1:0]   sum_i,
    input  logic        [DECIM_LOG2-1:0] dither_i,
    output slot_t                        slot_o,
    output logic                         clip_o
);

    // Wide enough for the gained sum plus dither and for both clamp limits.
    localparam int RAW_BITS  = ACC_BITS + GAIN_SHIFT + 1;
    localparam int WORK_BITS = (RAW_BITS > OUT_BITS + 1) ? RAW_BITS : OUT_BITS + 1;
    localparam logic signed [WORK_BITS-1:0] MAX_V = WORK_BITS'(2 ** (OUT_BITS - 1) - 1);
    localparam logic signed [WORK_BITS-1:0] MIN_V = ~MAX_V;

    logic signed [WORK_BITS-1:0] scaled;
    logic signed [WORK_BITS-1:0] biased;
    logic signed [WORK_BITS-1:0] averaged;
    logic signed [OUT_BITS-1:0]  clamped;

    always_comb begin
        scaled   = WORK_BITS'(sum_i) <<< GAIN_SHIFT;
        biased   = scaled + $signed(WORK_BITS'({1'b0, dither_i}));
        averaged = biased >>> DECIM_LOG2;
        clip_o   = 1'b0;
        clamped  = averaged[OUT_BITS-1:0];
        if (averaged > MAX_V) begin
            clamped = MAX_V[OUT_BITS-1:0];
            clip_o  = 1'b1;
        end else if (averaged < MIN_V) begin
            clamped = MIN_V[OUT_BITS-1:0];
            clip_o  = 1'b1;
        end
        slot_o = slot_t'(clamped) <<< (SLOT_BITS - OUT_BITS);
    end

endmodule

// File: rtl/audio_decimator.sv
// Stereo boxcar decimator feeding the SGTL5000 serial port with atomic 64-bit frames.
// Define AUDIO_DITHER_EN to add LFSR-based randomised rounding before the averaging shift.
module audio_decimator
    import audio_pkg::*;
#(
    parameter int IN_BITS    = 22,
    parameter int OUT_BITS   = 24,
    parameter int DECIM_LOG2 = 5,
    parameter int GAIN_SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst,
    audio_decimator_if.slave  bus
);

    localparam int ACC_BITS = IN_BITS + DECIM_LOG2;
    localparam logic [DECIM_LOG2-1:0] COUNT_MAX = '1;

    logic [DECIM_LOG2-1:0]      count_q, count_d;
    logic signed [ACC_BITS-1:0] accL_q, accL_d, accR_q, accR_d;
    logic signed [ACC_BITS-1:0] s1L_q, s1L_d, s1R_q, s1R_d;
    logic                       s1Valid_q, s1Valid_d;
    frame_t                     audio_q, audio_d;
    logic                       outValid_q, outValid_d;
    logic                       clip_q, clip_d;

    logic signed [ACC_BITS-1:0] extL, extR;
    logic [DECIM_LOG2-1:0]      dither;
    slot_t                      slotL, slotR;
    logic                       clipL, clipR;

    assign extL = ACC_BITS'(bus.in_left);
    assign extR = ACC_BITS'(bus.in_right);

`ifdef AUDIO_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = s1Valid_q ? lfsrNext(lfsr_q) : lfsr_q;
    assign dither = lfsr_q[DECIM_LOG2-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= lfsr_d;
    end
`else
    assign dither = '0;
`endif

    // Stage 1: the last sample of a frame goes straight into the captured sum.
    always_comb begin
        count_d   = count_q;
        accL_d    = accL_q;
        accR_d    = accR_q;
        s1L_d     = s1L_q;
        s1R_d     = s1R_q;
        s1Valid_d = 1'b0;
        if (bus.in_valid) begin
            if (count_q == COUNT_MAX) begin
                s1L_d     = accL_q + extL;
                s1R_d     = accR_q + extR;
                accL_d    = '0;
                accR_d    = '0;
                count_d   = '0;
                s1Valid_d = 1'b1;
            end else begin
                accL_d  = accL_q + extL;
                accR_d  = accR_q + extR;
                count_d = count_q + DECIM_LOG2'(1);
            end
        end
    end

    audio_sat_scale #(
        .ACC_BITS   (ACC_BITS),
        .DECIM_LOG2 (DECIM_LOG2),
        .GAIN_SHIFT (GAIN_SHIFT),
        .OUT_BITS   (OUT_BITS)
    ) u_scaleL (
        .sum_i    (s1L_q),
        .dither_i (dither),
        .slot_o   (slotL),
        .clip_o   (clipL)
    );

    audio_sat_scale #(
        .ACC_BITS   (ACC_BITS),
        .DECIM_LOG2 (DECIM_LOG2),
        .GAIN_SHIFT (GAIN_SHIFT),
        .OUT_BITS   (OUT_BITS)
    ) u_scaleR (
        .sum_i    (s1R_q),
        .dither_i (dither),
        .slot_o   (slotR),
        .clip_o   (clipR)
    );

    // Stage 2: clip is flagged even for muted frames; a new clamp beats clip_clr.
    always_comb begin
        audio_d    = audio_q;
        outValid_d = s1Valid_q;
        clip_d     = clip_q;
        if (bus.clip_clr) clip_d = 1'b0;
        if (s1Valid_q) begin
            if (bus.mute) begin
                audio_d = '0;
            end else begin
                audio_d.left  = slotL;
                audio_d.right = slotR;
            end
            if (clipL || clipR) clip_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            accL_q     <= '0;
            accR_q     <= '0;
            s1L_q      <= '0;
            s1R_q      <= '0;
            s1Valid_q  <= 1'b0;
            audio_q    <= '0;
            outValid_q <= 1'b0;
            clip_q     <= 1'b0;
        end else begin
            count_q    <= count_d;
            accL_q     <= accL_d;
            accR_q     <= accR_d;
            s1L_q      <= s1L_d;
            s1R_q      <= s1R_d;
            s1Valid_q  <= s1Valid_d;
            audio_q    <= audio_d;
            outValid_q <= outValid_d;
            clip_q     <= clip_d;
        end
    end

    assign bus.audio_o   = audio_q;
    assign bus.out_valid = outValid_q;
    assign bus.clip      = clip_q;

endmodule

// File: tb/tb_audio_decimator.sv
// Bench for audio_decimator (DECIM_LOG2=2, GAIN_SHIFT=3, OUT_BITS=24, no dither):
// arithmetic reference model checked every cycle, plus literal frame expectations.
module tb_audio_decimator;

    localparam int IN_BITS    = 22;
    localparam int OUT_BITS   = 24;
    localparam int DECIM_LOG2 = 2;
    localparam int GAIN_SHIFT = 3;
    localparam int FRAME_LEN  = 1 << DECIM_LOG2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    audio_decimator_if #(.IN_BITS(IN_BITS)) bus ();

    audio_decimator #(
        .IN_BITS    (IN_BITS),
        .OUT_BITS   (OUT_BITS),
        .DECIM_LOG2 (DECIM_LOG2),
        .GAIN_SHIFT (GAIN_SHIFT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Average of FRAME_LEN samples scaled by 2**GAIN_SHIFT, rounded toward -inf, saturated.
    function automatic void modelChannel(input longint sum, output logic [31:0] slot, output bit clipped);
        longint maxV = (longint'(1) << (OUT_BITS - 1)) - 1;
        longint minV = -maxV - 1;
        longint scaled;
        longint v;
        scaled = sum * (longint'(1) << GAIN_SHIFT);
        v = scaled / FRAME_LEN;
        if ((scaled % FRAME_LEN) != 0 && scaled < 0) v = v - 1;
        clipped = 1'b0;
        if (v > maxV) begin
            v = maxV;
            clipped = 1'b1;
        end else if (v < minV) begin
            v = minV;
            clipped = 1'b1;
        end
        slot = 32'(v) << (32 - OUT_BITS);
    endfunction

    int          qL[$];
    int          qR[$];
    longint      sumL, sumR;
    logic [31:0] mSlotL, mSlotR;
    bit          mClipL, mClipR;
    bit          pend = 1'b0;
    bit          pendClip = 1'b0;
    logic [63:0] pendFrame = '0;
    logic [63:0] expAudio = '0;
    bit          expValid = 1'b0;
    bit          expClip = 1'b0;

    // Reference model: a completed frame becomes visible one edge after its last sample.
    always @(posedge clk) begin
        if (rst) begin
            qL.delete();
            qR.delete();
            pend     = 1'b0;
            expAudio = '0;
            expValid = 1'b0;
            expClip  = 1'b0;
        end else begin
            expValid = 1'b0;
            if (bus.clip_clr) expClip = 1'b0;
            if (pend) begin
                expValid = 1'b1;
                expAudio = bus.mute ? 64'd0 : pendFrame;
                if (pendClip) expClip = 1'b1;
                pend = 1'b0;
            end
            if (bus.in_valid) begin
                qL.push_back(int'(bus.in_left));
                qR.push_back(int'(bus.in_right));
                if (qL.size() == FRAME_LEN) begin
                    sumL = 0;
                    sumR = 0;
                    foreach (qL[i]) sumL += qL[i];
                    foreach (qR[i]) sumR += qR[i];
                    modelChannel(sumL, mSlotL, mClipL);
                    modelChannel(sumR, mSlotR, mClipR);
                    pendFrame = {mSlotL, mSlotR};
                    pendClip  = mClipL | mClipR;
                    pend      = 1'b1;
                    qL.delete();
                    qR.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("model out_valid", 64'(bus.out_valid), 64'(expValid));
            checkOutput("model audio_o", 64'(bus.audio_o), expAudio);
            checkOutput("model clip", 64'(bus.clip), 64'(expClip));
        end
    end

    task automatic applyStimulus(input int l, input int r);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_left  = IN_BITS'(l);
        bus.in_right = IN_BITS'(r);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic sendFrame(input int l, input int r);
        repeat (FRAME_LEN) applyStimulus(l, r);
    endtask

    // Called right after the last sample of a frame was driven.
    task automatic checkFrame(input string name, input logic [63:0] expFrame,
                              input logic expClipVal, input logic clrAtOutput);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.clip_clr = clrAtOutput;
        checkOutput({name, " early"}, 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        bus.clip_clr = 1'b0;
        checkOutput({name, " out_valid"}, 64'(bus.out_valid), 64'd1);
        checkOutput({name, " audio_o"}, 64'(bus.audio_o), expFrame);
        checkOutput({name, " clip"}, 64'(bus.clip), 64'(expClipVal));
        @(posedge clk);
        #1;
        checkOutput({name, " pulse end"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_left  = '0;
        bus.in_right = '0;
        bus.mute     = 1'b0;
        bus.clip_clr = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset audio_o", 64'(bus.audio_o), 64'd0);
        checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset clip", 64'(bus.clip), 64'd0);
        rst = 1'b0;
        idle(4);
        checkOutput("idle out_valid", 64'(bus.out_valid), 64'd0);

        $display("[TB] basic frame");
        sendFrame(1000, -1000);
        checkFrame("basic", 64'h001F4000_FFE0C000, 1'b0, 1'b0);

        $display("[TB] saturation and clip");
        sendFrame(2097151, -2097152);
        checkFrame("sat", 64'h7FFFFF00_80000000, 1'b1, 1'b0);
        idle(3);
        checkOutput("clip sticky", 64'(bus.clip), 64'd1);
        bus.clip_clr = 1'b1;
        idle(1);
        bus.clip_clr = 1'b0;
        idle(1);
        checkOutput("clip cleared", 64'(bus.clip), 64'd0);
        sendFrame(2097151, -2097152);
        checkFrame("sat set-wins", 64'h7FFFFF00_80000000, 1'b1, 1'b1);
        bus.clip_clr = 1'b1;
        idle(1);
        bus.clip_clr = 1'b0;
        idle(1);

        $display("[TB] mute");
        bus.mute = 1'b1;
        sendFrame(1000, 1000);
        checkFrame("muted", 64'd0, 1'b0, 1'b0);
        bus.mute = 1'b0;
        sendFrame(1000, 1000);
        checkFrame("unmuted", 64'h001F4000_001F4000, 1'b0, 1'b0);
        idle(2);

        $display("[TB] back-to-back ramp");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(i, i);
            if (i == 5) checkOutput("ramp frame0", 64'(bus.audio_o), 64'h00000C00_00000C00);
            if (i == 9) checkOutput("ramp frame1", 64'(bus.audio_o), 64'h00002C00_00002C00);
        end
        checkFrame("ramp frame2", 64'h00004C00_00004C00, 1'b0, 1'b0);
        idle(2);

        $display("[TB] reset mid-frame");
        applyStimulus(1000, 1000);
        applyStimulus(1000, 1000);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("mid-reset audio_o", 64'(bus.audio_o), 64'd0);
        idle(4);
        checkOutput("mid-reset no out_valid", 64'(bus.out_valid), 64'd0);
        sendFrame(1000, 1000);
        checkFrame("after reset", 64'h001F4000_001F4000, 1'b0, 1'b0);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
